router_pkt_tx: RTL

// - Upstream packet source for the 1x3 router: accepts a request (dest, length), buffers the payload,

---
 rtl/router_pkg.sv | 28 ++
 rtl/router_tx_buf.sv | 32 +++
 rtl/router_pkt_tx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared types and helpers for the router packet transmitter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: tx_state_t FSM encoding, field widths, illegal address code and the header packing helper.
package router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HEADER,
    PAYLOAD,
    PARITY,
    GAP
  } tx_state_t;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'd3;

  // Header byte as the router expects it: length in the top six bits, port in the bottom two.
  function automatic logic [DATA_W-1:0] hdr(input logic [LEN_W-1:0]  len,
                                            input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload staging buffer: one write port, one combinational read port, no storage reset.
// Latency: write lands on the clock edge; read data follows rd_addr in the same cycle.
// Backpressure: none; the owner only writes while it is accepting payload.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_addr/rd_data asynchronous read port.
module router_tx_buf
  import router_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = DATA_W
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  // Contents are only ever read after being written for the current packet,
  // so the array carries no reset.
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for the 1x3 router: take a request, buffer the payload, send header/payload/parity.
// Latency: header appears the cycle after the last payload byte is written; one byte per busy=0 edge.
// Backpressure: busy=1 freezes data/pkt_valid; req_ready only in IDLE, pay_ready only in LOAD.
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_addr/req_len/corrupt_par request;
//        pay_valid/pay_ready/pay_data payload; busy, err from router; data, pkt_valid to router;
//        req_err, tx_done status pulses; err_cnt saturating count of err rising edges.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int MAX_LEN    = 64,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              corrupt_par,
  input  logic              pay_valid,
  output logic              pay_ready,
  input  logic [DATA_W-1:0] pay_data,
  input  logic              busy,
  input  logic              err,
  output logic [DATA_W-1:0] data,
  output logic              pkt_valid,
  output logic              req_err,
  output logic              tx_done,
  output logic [7:0]        err_cnt
);

  // Gap counter is 8 bits wide, so GAP_CYCLES is limited to 256.
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  tx_state_t         state;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W-1:0] addr_q;
  logic              corrupt_q;
  logic [LEN_W-1:0]  wptr;
  logic [LEN_W-1:0]  rptr;
  logic [DATA_W-1:0] parity;
  logic [7:0]        gap_cnt;
  logic              err_d;

  logic              buf_wr_en;
  logic [LEN_W-1:0]  buf_rd_addr;
  logic [DATA_W-1:0] buf_rd_data;

  // Because data is registered, the buffer is read one byte ahead: in HEADER
  // we fetch byte 0, in PAYLOAD the byte after the one currently on the wire.
  always_comb begin
    buf_rd_addr = rptr + LEN_W'(1);
    if (state == HEADER) begin
      buf_rd_addr = '0;
    end
  end

  assign buf_wr_en = (state == LOAD) && pay_valid && pay_ready;

  router_tx_buf #(
    .DEPTH (MAX_LEN),
    .AW    (LEN_W),
    .DW    (DATA_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_addr (wptr),
    .wr_data (pay_data),
    .rd_addr (buf_rd_addr),
    .rd_data (buf_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      addr_q    <= '0;
      corrupt_q <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      parity    <= '0;
      gap_cnt   <= '0;
      err_d     <= 1'b0;
      err_cnt   <= '0;
      data      <= '0;
      pkt_valid <= 1'b0;
      req_ready <= 1'b0;
      pay_ready <= 1'b0;
      req_err   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      req_err <= 1'b0;
      tx_done <= 1'b0;

      // Error monitor runs in every state, independent of the transmit FSM.
      err_d <= err;
      if (err && !err_d && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end

      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            if ((req_len == '0) || (req_addr == ADDR_ILLEGAL)) begin
              req_err <= 1'b1;
            end else begin
              len_q     <= req_len;
              addr_q    <= req_addr;
              corrupt_q <= corrupt_par;
              // The header byte is part of the parity, so seed with it.
              parity    <= hdr(req_len, req_addr);
              wptr      <= '0;
              req_ready <= 1'b0;
              pay_ready <= 1'b1;
              state     <= LOAD;
            end
          end
        end

        LOAD: begin
          if (pay_valid && pay_ready) begin
            parity <= parity ^ pay_data;
            wptr   <= wptr + LEN_W'(1);
            if (wptr == len_q - LEN_W'(1)) begin
              pay_ready <= 1'b0;
              data      <= hdr(len_q, addr_q);
              pkt_valid <= 1'b1;
              state     <= HEADER;
            end
          end
        end

        HEADER: begin
          if (!busy) begin
            rptr  <= '0;
            data  <= buf_rd_data;
            state <= PAYLOAD;
          end
        end

        PAYLOAD: begin
          if (!busy) begin
            if (rptr == len_q - LEN_W'(1)) begin
              data      <= parity ^ {{(DATA_W-1){1'b0}}, corrupt_q};
              pkt_valid <= 1'b0;
              state     <= PARITY;
            end else begin
              rptr <= rptr + LEN_W'(1);
              data <= buf_rd_data;
            end
          end
        end

        PARITY: begin
          if (!busy) begin
            tx_done <= 1'b1;
            data    <= '0;
            if (GAP_CYCLES == 0) begin
              req_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              gap_cnt <= '0;
              state   <= GAP;
            end
          end
        end

        GAP: begin
          if (gap_cnt == 8'(GAP_LAST)) begin
            req_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        default: begin
          data      <= '0;
          pkt_valid <= 1'b0;
          pay_ready <= 1'b0;
          req_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
